mem_response_merger: RTL and testbench
======================================

# mem_response_merger

Write-response merger on the store path's AXI B channel. The store request path breaks a 4 KB-crossing write into two AXI bursts. This block records, per original request, whether it was split. It then consumes one or two AXI B responses per request and returns exactly one completion to the store controller, with the response codes merged.

## Interface

Parameters:
- MAX_OUTSTANDING, 8: depth of the request-tracking FIFO; must be a power of 2, at least 2.
- RESP_WIDTH, 2: AXI BRESP width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- req_push  in  1  one original request issued to AXI this cycle.
- req_split  in  1  qualifies req_push; 1 means the request was issued as two bursts.
- req_full  out  1  tracking FIFO full; upstream must not assert req_push.
- axi_bvalid  in  1  AXI write-response valid.
- axi_bresp  in  RESP_WIDTH  AXI write-response code.
- axi_bready  out  1  AXI write-response ready.
- cmpl_valid  out  1  merged completion valid.
- cmpl_resp  out  RESP_WIDTH  merged response code.
- cmpl_ready  in  1  completion accepted.
- outstanding_count  out  $clog2(MAX_OUTSTANDING)+1  tracked requests not yet completed.
- idle  out  1  FIFO empty and FSM in WAIT_FIRST.
- err_overflow  out  1  sticky; req_push was seen while req_full.
- err_unexpected  out  1  sticky; axi_bvalid was seen while the FIFO was empty.

## Operation

- Tracking FIFO holds one split flag per entry.
  - Write pointer and read pointer are each log2(MAX_OUTSTANDING)+1 bits; wrap-around uses the extra MSB.
  - Full: pointers differ only in the MSB. Empty: pointers are equal.
  - Push happens on req_push && !req_full.
  - A push while full is dropped and sets err_overflow.
- FSM states: WAIT_FIRST, WAIT_SECOND, CMPL.
  - WAIT_FIRST: axi_bready = !fifo_empty. On a B handshake, latch resp_a = axi_bresp.
    - If head flag = 0, go to CMPL with cmpl_resp = resp_a.
    - If head flag = 1, go to WAIT_SECOND.
  - WAIT_SECOND: axi_bready = 1. On a B handshake, cmpl_resp = max(resp_a, axi_bresp), compared as unsigned, so the priority is DECERR > SLVERR > EXOKAY > OKAY. Then go to CMPL.
  - CMPL: axi_bready = 0 and cmpl_valid = 1. cmpl_valid and cmpl_resp hold stable until cmpl_ready. On the handshake, pop the FIFO head and go to WAIT_FIRST.
- Simultaneous push and pop in the same cycle: both take effect; the count is unchanged, including when the FIFO is full.
- The head entry stays in the FIFO until its completion handshake, so outstanding_count includes the request currently being merged.
- axi_bvalid while the FIFO is empty in WAIT_FIRST: the beat is not accepted (bready = 0) and err_unexpected sets.
- Sticky errors clear only on reset.
- Reset mid-operation: FIFO pointers, FSM, latched responses and error flags are all cleared, and any partially merged request is discarded.

## Timing

- All outputs come from registered state. axi_bready, req_full, idle and outstanding_count are decoded from registered FSM state and pointers, with no combinational path from axi_bvalid or req_push.
- Reset values:
  - axi_bready = 0, cmpl_valid = 0, cmpl_resp = 0, req_full = 0.
  - outstanding_count = 0, idle = 1.
  - err_overflow = 0, err_unexpected = 0.
- A push in cycle N is visible in cycle N+1: outstanding_count increments, and axi_bready can rise in N+1 if the FIFO was empty.
- Last B beat accepted in cycle N gives cmpl_valid = 1 in cycle N+1.
- Completion handshake in cycle M:
  - cmpl_valid = 0 in M+1.
  - If entries remain, axi_bready = 1 in M+1.
- Throughput:
  - Unsplit request: one completion every 2 cycles.
  - Split request: one completion every 3 cycles, with cmpl_ready held high and B responses back-to-back.
- The single-beat cost on axi_bready after each completion is required.

## Test plan

- Single unsplit request: push (split=0), bresp = 0 two cycles later → one completion, cmpl_resp = 0, one cycle after the B handshake; count goes 1 then 0; idle = 1 afterwards.
- Single split request: push (split=1), then B responses 0 and 2 → exactly one completion with cmpl_resp = 2, no completion after the first B; repeat with responses 3 then 0 → cmpl_resp = 3.
- Mixed sequence: push split flags 0,1,1,0 and return six B beats, with bvalid randomly delayed and cmpl_ready stalled 3 cycles on the 2nd completion → four completions in order; cmpl_resp held stable through the stall; bready = 0 during the stall.
- Fill and overflow: 8 pushes with no B responses → req_full = 1 and count = 8; a 9th push → err_overflow = 1, count stays 8; a push coinciding with a completion pop while full → count stays 8 and no overflow is flagged.
- Unexpected response: bvalid = 1 with the FIFO empty → axi_bready = 0, err_unexpected = 1 next cycle, and no completion.
- Reset mid-merge: reset asserted in WAIT_SECOND with 3 entries outstanding → next cycle count = 0, cmpl_valid = 0, axi_bready = 0, idle = 1, errors = 0.

Source files
------------

// File: rtl/mem_response_merger_if.sv
// Handshake bundle for the write-response merger: request tracking,
// AXI B channel and the merged completion toward the store controller.
interface mem_response_merger_if #(
  parameter int RESP_WIDTH = 2
);
  logic                  req_push;
  logic                  req_split;
  logic                  req_full;
  logic                  axi_bvalid;
  logic [RESP_WIDTH-1:0] axi_bresp;
  logic                  axi_bready;
  logic                  cmpl_valid;
  logic [RESP_WIDTH-1:0] cmpl_resp;
  logic                  cmpl_ready;

  modport slave (
    input  req_push, req_split, axi_bvalid, axi_bresp, cmpl_ready,
    output req_full, axi_bready, cmpl_valid, cmpl_resp
  );

  modport master (
    output req_push, req_split, axi_bvalid, axi_bresp, cmpl_ready,
    input  req_full, axi_bready, cmpl_valid, cmpl_resp
  );
endinterface

// File: rtl/mem_response_merger.sv
// Merges one or two AXI B beats per store request into a single completion,
// keeping the worst response code; a FIFO tracks which requests were split.
module mem_response_merger #(
  parameter  int MAX_OUTSTANDING = 8,
  parameter  int RESP_WIDTH      = 2,
  localparam int AW              = $clog2(MAX_OUTSTANDING),
  localparam int PW              = AW + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  mem_response_merger_if.slave  bus,
  output logic [PW-1:0]         outstanding_count,
  output logic                  idle,
  output logic                  err_overflow,
  output logic                  err_unexpected
);

  typedef enum logic [1:0] {
    WAIT_FIRST  = 2'd0,
    WAIT_SECOND = 2'd1,
    CMPL        = 2'd2
  } state_t;

  state_t                state, state_n;
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [MAX_OUTSTANDING-1:0] split_q;
  logic [RESP_WIDTH-1:0] resp_a, resp_a_n;
  logic [RESP_WIDTH-1:0] cmpl_resp_q, cmpl_resp_n;

  logic fifo_empty, fifo_full, head_split;
  logic push, pop, overflow, b_hs;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head_split = split_q[rd_ptr[AW-1:0]];

  // A push into a full FIFO is still accepted when the head retires in the
  // same cycle: the freed slot is the one being written.
  assign pop      = (state == CMPL) && bus.cmpl_ready;
  assign push     = bus.req_push && (!fifo_full || pop);
  assign overflow = bus.req_push && fifo_full && !pop;

  assign bus.axi_bready = ((state == WAIT_FIRST) && !fifo_empty) ||
                          (state == WAIT_SECOND);
  assign b_hs           = bus.axi_bvalid && bus.axi_bready;

  assign bus.req_full   = fifo_full;
  assign bus.cmpl_valid = (state == CMPL);
  assign bus.cmpl_resp  = cmpl_resp_q;

  assign outstanding_count = wr_ptr - rd_ptr;
  assign idle              = fifo_empty && (state == WAIT_FIRST);

  always_comb begin
    state_n     = state;
    resp_a_n    = resp_a;
    cmpl_resp_n = cmpl_resp_q;
    case (state)
      WAIT_FIRST: begin
        if (b_hs) begin
          resp_a_n = bus.axi_bresp;
          if (head_split) begin
            state_n = WAIT_SECOND;
          end else begin
            cmpl_resp_n = bus.axi_bresp;
            state_n     = CMPL;
          end
        end
      end
      WAIT_SECOND: begin
        if (b_hs) begin
          // BRESP encodings are ordered by severity, so unsigned max merges.
          cmpl_resp_n = (bus.axi_bresp > resp_a) ? bus.axi_bresp : resp_a;
          state_n     = CMPL;
        end
      end
      CMPL: begin
        if (bus.cmpl_ready) state_n = WAIT_FIRST;
      end
      default: state_n = WAIT_FIRST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= WAIT_FIRST;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      resp_a         <= '0;
      cmpl_resp_q    <= '0;
      err_overflow   <= 1'b0;
      err_unexpected <= 1'b0;
    end else begin
      state       <= state_n;
      resp_a      <= resp_a_n;
      cmpl_resp_q <= cmpl_resp_n;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (overflow) err_overflow <= 1'b1;
      if (bus.axi_bvalid && fifo_empty) err_unexpected <= 1'b1;
    end
  end

  // Flag storage needs no reset; entries are only read behind the pointers.
  always_ff @(posedge clk) begin
    if (push) split_q[wr_ptr[AW-1:0]] <= bus.req_split;
  end

endmodule

// File: tb/tb_mem_response_merger.sv
// Directed bench for mem_response_merger: unsplit/split merging, mixed
// traffic with stalls, fill/overflow, unexpected beats and mid-merge reset.
module tb_mem_response_merger;

  logic       clk;
  logic       reset;
  logic [3:0] count;
  logic       idle, err_ovf, err_unx;
  int         checks, errors;

  mem_response_merger_if #(.RESP_WIDTH(2)) bus ();

  mem_response_merger #(.MAX_OUTSTANDING(8), .RESP_WIDTH(2)) dut (
    .clk               (clk),
    .reset             (reset),
    .bus               (bus),
    .outstanding_count (count),
    .idle              (idle),
    .err_overflow      (err_ovf),
    .err_unexpected    (err_unx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic push(input logic split);
    bus.req_push  = 1'b1;
    bus.req_split = split;
    tick();
    bus.req_push  = 1'b0;
    bus.req_split = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.axi_bready !== 1'b0) begin errors++; $display("FAIL reset_bready got %b want 0", bus.axi_bready); end
    checks++; if (bus.cmpl_valid !== 1'b0) begin errors++; $display("FAIL reset_cvalid got %b want 0", bus.cmpl_valid); end
    checks++; if (bus.cmpl_resp !== 2'd0) begin errors++; $display("FAIL reset_cresp got %0d want 0", bus.cmpl_resp); end
    checks++; if (bus.req_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", bus.req_full); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle got %b want 1", idle); end
    checks++; if ({err_ovf, err_unx} !== 2'b00) begin errors++; $display("FAIL reset_errs got %b want 00", {err_ovf, err_unx}); end
  endtask

  task automatic test_unsplit();
    push(1'b0);
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL unsplit_count1 got %0d want 1", count); end
    checks++; if (bus.axi_bready !== 1'b1) begin errors++; $display("FAIL unsplit_bready got %b want 1", bus.axi_bready); end
    tick();
    bus.axi_bvalid = 1'b1;
    bus.axi_bresp  = 2'd0;
    tick();
    bus.axi_bvalid = 1'b0;
    checks++; if (bus.cmpl_valid !== 1'b1) begin errors++; $display("FAIL unsplit_cvalid got %b want 1", bus.cmpl_valid); end
    checks++; if (bus.cmpl_resp !== 2'd0) begin errors++; $display("FAIL unsplit_cresp got %0d want 0", bus.cmpl_resp); end
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL unsplit_count_hold got %0d want 1", count); end
    bus.cmpl_ready = 1'b1;
    tick();
    bus.cmpl_ready = 1'b0;
    checks++; if (bus.cmpl_valid !== 1'b0) begin errors++; $display("FAIL unsplit_cvalid_drop got %b want 0", bus.cmpl_valid); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL unsplit_count0 got %0d want 0", count); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL unsplit_idle got %b want 1", idle); end
  endtask

  task automatic test_split();
    logic [1:0] r0 [2];
    logic [1:0] r1 [2];
    logic [1:0] ex [2];
    r0 = '{2'd0, 2'd3};
    r1 = '{2'd2, 2'd0};
    ex = '{2'd2, 2'd3};
    for (int i = 0; i < 2; i++) begin
      push(1'b1);
      bus.axi_bvalid = 1'b1;
      bus.axi_bresp  = r0[i];
      tick();
      checks++; if (bus.cmpl_valid !== 1'b0) begin errors++; $display("FAIL split_early_cvalid[%0d] got %b want 0", i, bus.cmpl_valid); end
      checks++; if (bus.axi_bready !== 1'b1) begin errors++; $display("FAIL split_second_bready[%0d] got %b want 1", i, bus.axi_bready); end
      bus.axi_bresp = r1[i];
      tick();
      bus.axi_bvalid = 1'b0;
      checks++; if (bus.cmpl_valid !== 1'b1) begin errors++; $display("FAIL split_cvalid[%0d] got %b want 1", i, bus.cmpl_valid); end
      checks++; if (bus.cmpl_resp !== ex[i]) begin errors++; $display("FAIL split_cresp[%0d] got %0d want %0d", i, bus.cmpl_resp, ex[i]); end
      bus.cmpl_ready = 1'b1;
      tick();
      bus.cmpl_ready = 1'b0;
      checks++; if (bus.cmpl_valid !== 1'b0) begin errors++; $display("FAIL split_single_cmpl[%0d] got %b want 0", i, bus.cmpl_valid); end
    end
  endtask

  task automatic test_mixed();
    logic [1:0] beats [6];
    logic [1:0] ex [4];
    beats = '{2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0};
    ex    = '{2'd1, 2'd3, 2'd2, 2'd0};
    push(1'b0);
    push(1'b1);
    push(1'b1);
    push(1'b0);
    checks++; if (count !== 4'd4) begin errors++; $display("FAIL mixed_count got %0d want 4", count); end
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          int d;
          int n;
          d = $urandom_range(0, 2);
          repeat (d) tick();
          bus.axi_bvalid = 1'b1;
          bus.axi_bresp  = beats[i];
          n = 0;
          while (bus.axi_bready !== 1'b1 && n < 50) begin tick(); n++; end
          if (n >= 50) begin checks++; errors++; $display("FAIL mixed_bready_timeout beat %0d got 0 want 1", i); end
          tick();
          bus.axi_bvalid = 1'b0;
        end
      end
      begin
        for (int k = 0; k < 4; k++) begin
          int n;
          n = 0;
          while (bus.cmpl_valid !== 1'b1 && n < 80) begin tick(); n++; end
          if (n >= 80) begin checks++; errors++; $display("FAIL mixed_cmpl_timeout cmpl %0d got 0 want 1", k); end
          checks++; if (bus.cmpl_resp !== ex[k]) begin errors++; $display("FAIL mixed_cresp[%0d] got %0d want %0d", k, bus.cmpl_resp, ex[k]); end
          if (k == 1) begin
            for (int s = 0; s < 3; s++) begin
              checks++; if (bus.cmpl_valid !== 1'b1) begin errors++; $display("FAIL stall_cvalid[%0d] got %b want 1", s, bus.cmpl_valid); end
              checks++; if (bus.cmpl_resp !== ex[1]) begin errors++; $display("FAIL stall_cresp[%0d] got %0d want %0d", s, bus.cmpl_resp, ex[1]); end
              checks++; if (bus.axi_bready !== 1'b0) begin errors++; $display("FAIL stall_bready[%0d] got %b want 0", s, bus.axi_bready); end
              tick();
            end
          end
          bus.cmpl_ready = 1'b1;
          tick();
          bus.cmpl_ready = 1'b0;
        end
      end
    join
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL mixed_drain_count got %0d want 0", count); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL mixed_idle got %b want 1", idle); end
  endtask

  task automatic test_fill_overflow();
    do_reset();
    for (int i = 0; i < 8; i++) push(1'b0);
    checks++; if (bus.req_full !== 1'b1) begin errors++; $display("FAIL fill_full got %b want 1", bus.req_full); end
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL fill_count got %0d want 8", count); end
    bus.axi_bvalid = 1'b1;
    bus.axi_bresp  = 2'd1;
    tick();
    bus.axi_bvalid = 1'b0;
    checks++; if (bus.cmpl_valid !== 1'b1) begin errors++; $display("FAIL fill_cvalid got %b want 1", bus.cmpl_valid); end
    bus.req_push   = 1'b1;
    bus.cmpl_ready = 1'b1;
    tick();
    bus.req_push   = 1'b0;
    bus.cmpl_ready = 1'b0;
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL pushpop_count got %0d want 8", count); end
    checks++; if (err_ovf !== 1'b0) begin errors++; $display("FAIL pushpop_ovf got %b want 0", err_ovf); end
    checks++; if (bus.req_full !== 1'b1) begin errors++; $display("FAIL pushpop_full got %b want 1", bus.req_full); end
    checks++; if (bus.axi_bready !== 1'b1) begin errors++; $display("FAIL pushpop_bready got %b want 1", bus.axi_bready); end
    push(1'b0);
    checks++; if (err_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", err_ovf); end
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL ovf_count got %0d want 8", count); end
    do_reset();
  endtask

  task automatic test_unexpected();
    bus.axi_bvalid = 1'b1;
    bus.axi_bresp  = 2'd2;
    checks++; if (bus.axi_bready !== 1'b0) begin errors++; $display("FAIL unx_bready got %b want 0", bus.axi_bready); end
    tick();
    checks++; if (err_unx !== 1'b1) begin errors++; $display("FAIL unx_flag got %b want 1", err_unx); end
    checks++; if (bus.cmpl_valid !== 1'b0) begin errors++; $display("FAIL unx_cvalid got %b want 0", bus.cmpl_valid); end
    bus.axi_bvalid = 1'b0;
    tick();
    checks++; if (bus.cmpl_valid !== 1'b0) begin errors++; $display("FAIL unx_cvalid_later got %b want 0", bus.cmpl_valid); end
    checks++; if (err_unx !== 1'b1) begin errors++; $display("FAIL unx_sticky got %b want 1", err_unx); end
  endtask

  task automatic test_reset_mid();
    push(1'b1);
    push(1'b0);
    push(1'b0);
    bus.axi_bvalid = 1'b1;
    bus.axi_bresp  = 2'd1;
    tick();
    bus.axi_bvalid = 1'b0;
    checks++; if (count !== 4'd3) begin errors++; $display("FAIL mid_count got %0d want 3", count); end
    checks++; if (bus.axi_bready !== 1'b1) begin errors++; $display("FAIL mid_bready got %b want 1", bus.axi_bready); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL rst_count got %0d want 0", count); end
    checks++; if (bus.cmpl_valid !== 1'b0) begin errors++; $display("FAIL rst_cvalid got %b want 0", bus.cmpl_valid); end
    checks++; if (bus.axi_bready !== 1'b0) begin errors++; $display("FAIL rst_bready got %b want 0", bus.axi_bready); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rst_idle got %b want 1", idle); end
    checks++; if ({err_ovf, err_unx} !== 2'b00) begin errors++; $display("FAIL rst_errs got %b want 00", {err_ovf, err_unx}); end
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    reset          = 1'b0;
    bus.req_push   = 1'b0;
    bus.req_split  = 1'b0;
    bus.axi_bvalid = 1'b0;
    bus.axi_bresp  = 2'd0;
    bus.cmpl_ready = 1'b0;
    #2;
    test_reset();
    test_unsplit();
    test_split();
    test_mixed();
    test_fill_overflow();
    test_unexpected();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
